// File: rtl/hazard_scoreboard.sv
// Register-write scoreboard for an in-order pipeline: tracks pending writes per
// architectural register and stalls ID on RAW, WAW or a full in-flight window.
module hazard_scoreboard #(
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_wr_rd,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  output logic             stall,
  output logic             issue,
  output logic [31:0]      busy,
  output logic [2:0]       outstanding,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             hazard_rs1, hazard_rs2, hazard_waw, hazard_full;
  logic             wb_clr, issue_set;
  logic [31:0]      busy_d;
  logic [2:0]       outstanding_d;
  logic [CNT_W-1:0] stall_cnt_d;

  // A writeback only retires a write that is actually pending.
  assign wb_clr      = wb_en & (wb_rd != 5'd0) & busy[wb_rd];

  assign hazard_rs1  = id_use_rs1 & (id_rs1 != 5'd0) & busy[id_rs1];
  assign hazard_rs2  = id_use_rs2 & (id_rs2 != 5'd0) & busy[id_rs2];
  assign hazard_waw  = id_wr_rd & (id_rd != 5'd0) & busy[id_rd];
  assign hazard_full = id_wr_rd & (id_rd != 5'd0) & (outstanding == 3'(MAX_OUT)) & ~wb_clr;

  assign stall     = id_valid & (hazard_rs1 | hazard_rs2 | hazard_waw | hazard_full);
  assign issue     = id_valid & ~stall;
  assign issue_set = issue & id_wr_rd & (id_rd != 5'd0);

  always_comb begin
    busy_d = busy;
    if (wb_clr) busy_d[wb_rd] = 1'b0;
    // Set after clear so a same-register set wins.
    if (issue_set) busy_d[id_rd] = 1'b1;
    busy_d[0] = 1'b0;

    outstanding_d = outstanding;
    if (issue_set && !wb_clr) begin
      outstanding_d = outstanding + 3'd1;
    end else if (wb_clr && !issue_set) begin
      outstanding_d = outstanding - 3'd1;
    end

    stall_cnt_d = stall_cnt;
    if (stall && (stall_cnt != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= '0;
      outstanding <= '0;
      stall_cnt   <= '0;
    end else begin
      busy        <= busy_d;
      outstanding <= outstanding_d;
      stall_cnt   <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic against a
// per-register pending-write model; a CNT_W=4 instance covers counter saturation.
module tb_hazard_scoreboard;

  localparam int MAX_OUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0, wb_rd = '0;
  logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_wr_rd = 1'b0, wb_en = 1'b0;
  logic        stall, issue, stall4, issue4;
  logic [31:0] busy, busy4;
  logic [2:0]  outstanding, outstanding4;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt4;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one pending flag per register, plain integer counters.
  bit m_pend[32];
  int m_cnt;
  int m_cnt4;

  always #5 clk = ~clk;

  hazard_scoreboard #(.MAX_OUT(MAX_OUT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_wr_rd(id_wr_rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .stall(stall), .issue(issue), .busy(busy),
    .outstanding(outstanding), .stall_cnt(stall_cnt)
  );

  hazard_scoreboard #(.MAX_OUT(MAX_OUT), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_wr_rd(id_wr_rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .stall(stall4), .issue(issue4), .busy(busy4),
    .outstanding(outstanding4), .stall_cnt(stall_cnt4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_inflight();
    int n = 0;
    for (int r = 0; r < 32; r++) if (m_pend[r]) n++;
    return n;
  endfunction

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v = '0;
    for (int r = 0; r < 32; r++) v[r] = m_pend[r];
    return v;
  endfunction

  function automatic void m_reset();
    for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
    m_cnt  = 0;
    m_cnt4 = 0;
  endfunction

  // One clock: drive on negedge, check comb outputs, clock, check state.
  task automatic cycle(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic wr,
                       input logic we, input logic [4:0] wrd);
    bit retire, hz, e_stall, e_issue;
    @(negedge clk);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_wr_rd = wr; wb_en = we; wb_rd = wrd;
    retire  = we && wrd != 0 && m_pend[wrd];
    hz      = (u1 && rs1 != 0 && m_pend[rs1]) || (u2 && rs2 != 0 && m_pend[rs2]) ||
              (wr && rd != 0 && m_pend[rd]) ||
              (wr && rd != 0 && m_inflight() == MAX_OUT && !retire);
    e_stall = v && hz;
    e_issue = v && !e_stall;
    #1;
    check("stall", {31'd0, stall}, {31'd0, e_stall});
    check("issue", {31'd0, issue}, {31'd0, e_issue});
    check("stall4", {31'd0, stall4}, {31'd0, e_stall});
    @(posedge clk);
    if (retire) m_pend[wrd] = 1'b0;
    if (e_issue && wr && rd != 0) m_pend[rd] = 1'b1;
    if (e_stall) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    #1;
    check("busy", busy, m_busy_vec());
    check("outstanding", {29'd0, outstanding}, m_inflight());
    check("stall_cnt", {16'd0, stall_cnt}, m_cnt);
    check("stall_cnt4", {28'd0, stall_cnt4}, m_cnt4);
  endtask

  task automatic issue_wr(input logic [4:0] rd);
    cycle(1, 0, 0, 0, 0, rd, 1, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    m_reset();
    check("rst_busy", busy, 0);
    check("rst_out", {29'd0, outstanding}, 0);
    check("rst_cnt", {16'd0, stall_cnt}, 0);
    check("rst_stall", {31'd0, stall}, 0);
    check("rst_issue", {31'd0, issue}, {31'd0, id_valid});
    @(negedge clk);
    rst = 1'b0;
    id_valid = 0; id_wr_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0; wb_en = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    rst = 1'b1;
    #12 rst = 1'b0;
    check("init_busy", busy, 0);
    check("init_out", {29'd0, outstanding}, 0);

    // RAW on x5 with same-cycle writeback not forwarded.
    issue_wr(5);
    repeat (3) cycle(1, 5, 1, 0, 0, 0, 0, 0, 0);
    cycle(1, 5, 1, 0, 0, 0, 0, 1, 5);
    cycle(1, 5, 1, 0, 0, 0, 0, 0, 0);
    check("raw_cnt", {16'd0, stall_cnt}, 4);
    check("raw_busy5", {31'd0, busy[5]}, 0);

    // x0 never becomes busy.
    issue_wr(0);
    check("x0_busy", busy, 0);
    check("x0_out", {29'd0, outstanding}, 0);
    cycle(1, 0, 1, 0, 1, 0, 0, 0, 0);

    // Full window, then a retire in the same cycle lets rd=6 issue.
    for (int r = 1; r <= 4; r++) issue_wr(5'(r));
    check("full_out", {29'd0, outstanding}, 4);
    cycle(1, 0, 0, 0, 0, 6, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 6, 1, 1, 1);
    check("full_out_hold", {29'd0, outstanding}, 4);
    check("full_busy6", {31'd0, busy[6]}, 1);
    check("full_busy1", {31'd0, busy[1]}, 0);

    // WAW on x7 alongside its writeback: stall, then retry issues.
    do_reset();
    issue_wr(7);
    cycle(1, 0, 0, 0, 0, 7, 1, 1, 7);
    check("waw_clr", {31'd0, busy[7]}, 0);
    cycle(1, 0, 0, 0, 0, 7, 1, 0, 0);
    check("waw_set", {31'd0, busy[7]}, 1);

    // Build outstanding=3 and 20 stalls, then reset mid-cycle.
    do_reset();
    for (int r = 1; r <= 3; r++) issue_wr(5'(r));
    repeat (20) cycle(1, 2, 1, 0, 0, 0, 0, 0, 0);
    check("pre_rst_out", {29'd0, outstanding}, 3);
    check("pre_rst_cnt", {16'd0, stall_cnt}, 20);
    check("sat_cnt4", {28'd0, stall_cnt4}, 15);
    do_reset();
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 3);
    check("post_rst_out", {29'd0, outstanding}, 0);

    // Random traffic on a small register window so hazards are frequent.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 7)), 1'($urandom),
            5'($urandom_range(0, 7)), 1'($urandom),
            5'($urandom_range(0, 7)), 1'($urandom),
            1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL provide parameter MAX_OUT, default 4, meaning the maximum number of register writes in flight (legal range 1..7).
REQ-002 SHALL provide parameter CNT_W, default 16, meaning the width of the stall-cycle performance counter.
REQ-003 SHALL provide port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL provide port rst, input, 1, the reset, asynchronous and active-high.
REQ-005 SHALL provide port id_valid, input, 1, meaning a decoded instruction is present in ID.
REQ-006 SHALL provide ports id_rs1 and id_rs2, input, 5 each, meaning the source register indices from the decoder.
REQ-007 SHALL provide port id_rd, input, 5, meaning the destination register index.
REQ-008 SHALL provide ports id_use_rs1, id_use_rs2 and id_wr_rd, input, 1 each, meaning the instruction reads rs1, reads rs2, or writes rd.
REQ-009 SHALL provide port wb_en, input, 1, meaning a register-file write (WrEn) occurs this cycle.
REQ-010 SHALL provide port wb_rd, input, 5, meaning the register written this cycle.
REQ-011 SHALL provide port stall, output, 1, meaning hold the IF/ID stage (combinational).
REQ-012 SHALL provide port issue, output, 1, meaning the ID instruction advances this cycle (combinational).
REQ-013 SHALL provide port busy, output, 32, meaning the registered pending-write bit per architectural register.
REQ-014 SHALL provide port outstanding, output, 3, meaning the registered count of in-flight writes.
REQ-015 SHALL provide port stall_cnt, output, CNT_W, meaning the registered count of stalled cycles, saturating.

Function
REQ-016 SHALL compute hazard_rs1 = id_use_rs1 & (id_rs1!=0) & busy[id_rs1]; hazard_rs2 is computed likewise for rs2.
REQ-017 SHALL compute hazard_waw = id_wr_rd & (id_rd!=0) & busy[id_rd].
REQ-018 SHALL compute hazard_full = id_wr_rd & (id_rd!=0) & (outstanding==MAX_OUT) & !wb_clr, where wb_clr = wb_en & (wb_rd!=0) & busy[wb_rd].
REQ-019 SHALL drive stall = id_valid & (hazard_rs1 | hazard_rs2 | hazard_waw | hazard_full).
REQ-020 SHALL drive issue = id_valid & !stall, and shall drive both stall and issue to 0 when id_valid=0.
REQ-021 SHALL NOT forward a same-cycle writeback: a source register that is busy and being written this cycle still stalls, and the stall clears on the next cycle.
REQ-022 SHALL set busy[id_rd] on the next edge when issue & id_wr_rd & (id_rd!=0) (issue_set).
REQ-023 SHALL clear busy[wb_rd] on the next edge when wb_clr=1.
REQ-024 SHALL, when issue_set and wb_clr target the same register in one cycle, leave that bit set (the set wins); per REQ-017 this case only arises when the register was not busy, so no clear is lost.
REQ-025 SHALL hold busy[0]=0 at all times; writes to or issues targeting x0 neither set busy nor change outstanding.
REQ-026 SHALL ignore a wb_en to a non-busy register, changing neither busy nor outstanding.
REQ-027 SHALL update outstanding by +1 on issue_set only, -1 on wb_clr only, and 0 on both or neither; it shall never exceed MAX_OUT or go below 0.
REQ-028 SHALL keep outstanding equal to the population count of busy at every edge.
REQ-029 SHALL increment stall_cnt by 1 on each edge where stall=1, saturating at 2^CNT_W-1 with no wrap.
REQ-030 SHALL have zero-cycle latency from inputs to stall/issue, and one-cycle latency from issue/wb to busy/outstanding.

Reset
REQ-031 SHALL, on rst=1 and without waiting for clk, force busy=0, outstanding=0 and stall_cnt=0.
REQ-032 SHALL, while rst=1, produce stall=0 because busy=0; issue then follows id_valid.
REQ-033 SHALL discard all pending writes on reset mid-operation; a wb_en arriving after reset deasserts is ignored per REQ-026.
REQ-034 SHALL take its first state update on the first rising clk edge after rst deasserts.

Verification
REQ-035 SHALL verify RAW: issue rd=5, then id_rs1=5 with use_rs1 -> stall=1 each cycle until wb_en with wb_rd=5; stall=0 the cycle after; stall_cnt equals the number of stalled cycles.
REQ-036 SHALL verify x0: issue rd=0, then read rs1=0 -> busy=0, outstanding=0, and no stall ever.
REQ-037 SHALL verify full: issue rd=1..4 with MAX_OUT=4 -> outstanding=4; a write to rd=6 stalls; the same cycle with wb_en, wb_rd=1 -> issue=1 and outstanding stays 4.
REQ-038 SHALL verify a same-cycle set and clear: busy[7]=1 with a WAW request for rd=7 alongside wb_rd=7 -> stall=1 and busy[7]=0 next cycle; the retry then issues and busy[7]=1.
REQ-039 SHALL verify asynchronous reset: assert rst mid-cycle with outstanding=3 and stall_cnt=20 -> all outputs zero before the next edge; a later wb_en for rd=3 leaves outstanding=0.
REQ-040 SHALL verify saturation: with CNT_W=4, hold a stall for 20 cycles -> stall_cnt=15.
